// File: rtl/stereo_row_streamer_pkg.sv
// Shared types and defaults for the stereo row streamer and its strobe lanes.
package stereo_row_streamer_pkg;

  localparam int unsigned DEF_PIX_W   = 9;
  localparam int unsigned DEF_ROW_LEN = 800;
  localparam int unsigned DEF_ROW_GAP = 2048;
  localparam int unsigned DEF_ROWS    = 600;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int unsigned safe_clog2(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/stereo_strobe_lane.sv
// One eye's lane: pops upstream pixels and re-emits each as a single-cycle
// strobe with held data, at most one strobe every two cycles, ROW_LEN per row.
module stereo_strobe_lane
  import stereo_row_streamer_pkg::*;
#(
  parameter int unsigned ROW_LEN = DEF_ROW_LEN,
  parameter int unsigned PIX_W   = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             s_valid_i,
  input  logic [PIX_W-1:0] s_data_i,
  output logic             s_ready_o,
  output logic             valid_o,
  output logic [PIX_W-1:0] data_o,
  output logic             done_o
);

  localparam int unsigned CW = $clog2(ROW_LEN + 1);

  logic             valid_q;
  logic [PIX_W-1:0] data_q;
  logic [CW-1:0]    cnt_q;
  logic             pop_c;

  // Ready only between strobes and while the row quota is not yet met.
  always_comb begin
    s_ready_o = en_i & ~valid_q & (cnt_q < CW'(ROW_LEN));
    pop_c     = s_valid_i & s_ready_o;
    done_o    = (cnt_q == CW'(ROW_LEN)) & ~valid_q;
  end

  // Strobe follows a pop by one cycle; ready gating forces a low cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= pop_c;
      if (pop_c) begin
        data_q <= s_data_i;
      end
      if (clr_i) begin
        cnt_q <= '0;
      end else if (pop_c) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stereo_row_streamer.sv
// Row sequencer feeding the disparity core: sends ROW_LEN pixels per eye,
// idles ROW_GAP cycles for the core, tracks the row index within a frame.
module stereo_row_streamer
  import stereo_row_streamer_pkg::*;
#(
  parameter  int unsigned ROW_LEN = DEF_ROW_LEN,
  parameter  int unsigned ROW_GAP = DEF_ROW_GAP,
  parameter  int unsigned ROWS    = DEF_ROWS,
  parameter  int unsigned PIX_W   = DEF_PIX_W,
  localparam int unsigned RW      = safe_clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             s_l_valid,
  input  logic [PIX_W-1:0] s_l_data,
  output logic             s_l_ready,
  input  logic             s_r_valid,
  input  logic [PIX_W-1:0] s_r_data,
  output logic             s_r_ready,
  output logic             o_valid_l,
  output logic [PIX_W-1:0] o_data_l,
  output logic             o_valid_r,
  output logic [PIX_W-1:0] o_data_r,
  output logic             o_busy,
  output logic [RW-1:0]    o_row_idx,
  output logic             o_frame_done
);

  localparam int unsigned GW = safe_clog2(ROW_GAP);

  state_e        state_q;
  logic [GW-1:0] gap_q;
  logic [RW-1:0] row_q;
  logic          busy_q;
  logic          frame_done_q;

  logic lane_en_c;
  logic lane_clr_c;
  logic l_done_c;
  logic r_done_c;

  // Lanes run only in SEND; counters clear on every transition into SEND.
  always_comb begin
    lane_en_c  = (state_q == ST_SEND);
    lane_clr_c = i_enable &
                 ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q == '0)));
  end

  stereo_strobe_lane #(
    .ROW_LEN (ROW_LEN),
    .PIX_W   (PIX_W)
  ) u_lane_l (
    .clk       (clk),
    .rst       (rst),
    .en_i      (lane_en_c),
    .clr_i     (lane_clr_c),
    .s_valid_i (s_l_valid),
    .s_data_i  (s_l_data),
    .s_ready_o (s_l_ready),
    .valid_o   (o_valid_l),
    .data_o    (o_data_l),
    .done_o    (l_done_c)
  );

  stereo_strobe_lane #(
    .ROW_LEN (ROW_LEN),
    .PIX_W   (PIX_W)
  ) u_lane_r (
    .clk       (clk),
    .rst       (rst),
    .en_i      (lane_en_c),
    .clr_i     (lane_clr_c),
    .s_valid_i (s_r_valid),
    .s_data_i  (s_r_data),
    .s_ready_o (s_r_ready),
    .valid_o   (o_valid_r),
    .data_o    (o_data_r),
    .done_o    (r_done_c)
  );

  // Row FSM: enable is sampled only when leaving IDLE and at the end of GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gap_q        <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_enable) begin
            state_q <= ST_SEND;
            busy_q  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (l_done_c && r_done_c) begin
            state_q <= ST_GAP;
            gap_q   <= GW'(ROW_GAP - 1);
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            if (row_q == RW'(ROWS - 1)) begin
              row_q        <= '0;
              frame_done_q <= 1'b1;
            end else begin
              row_q <= row_q + RW'(1);
            end
            if (i_enable) begin
              state_q <= ST_SEND;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_row_idx    = row_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_stereo_row_streamer.sv
// Directed bench for stereo_row_streamer with ROW_LEN=8, ROW_GAP=4, ROWS=2.
module tb_stereo_row_streamer;

  localparam int unsigned PIX_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_enable = 1'b0;
  logic             s_l_valid = 1'b0;
  logic [PIX_W-1:0] s_l_data = '0;
  logic             s_l_ready;
  logic             s_r_valid = 1'b0;
  logic [PIX_W-1:0] s_r_data = '0;
  logic             s_r_ready;
  logic             o_valid_l;
  logic [PIX_W-1:0] o_data_l;
  logic             o_valid_r;
  logic [PIX_W-1:0] o_data_r;
  logic             o_busy;
  logic [0:0]       o_row_idx;
  logic             o_frame_done;

  // Source controls written by the main sequence only.
  logic l_gate = 1'b0;
  logic r_gate = 1'b0;
  logic l_stall = 1'b0;

  // Monitor-owned strobe records.
  logic [PIX_W-1:0] lq[$];
  logic [PIX_W-1:0] rq[$];
  int b2b_l = 0;
  int b2b_r = 0;

  int checks = 0;
  int errors = 0;

  stereo_row_streamer #(
    .ROW_LEN (8),
    .ROW_GAP (4),
    .ROWS    (2),
    .PIX_W   (PIX_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .s_l_valid    (s_l_valid),
    .s_l_data     (s_l_data),
    .s_l_ready    (s_l_ready),
    .s_r_valid    (s_r_valid),
    .s_r_data     (s_r_data),
    .s_r_ready    (s_r_ready),
    .o_valid_l    (o_valid_l),
    .o_data_l     (o_data_l),
    .o_valid_r    (o_valid_r),
    .o_data_r     (o_data_r),
    .o_busy       (o_busy),
    .o_row_idx    (o_row_idx),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  // Upstream sources: incrementing pixel streams starting at 1, advanced on pop.
  initial begin
    int l_next = 1;
    int r_next = 1;
    logic l_arm = 1'b0;
    logic r_arm = 1'b0;
    forever begin
      @(negedge clk);
      if (l_arm) l_next++;
      if (r_arm) r_next++;
      s_l_valid = l_gate && (!l_stall || ($urandom_range(0, 1) == 1));
      s_l_data  = PIX_W'(l_next);
      s_r_valid = r_gate;
      s_r_data  = PIX_W'(r_next);
      l_arm = s_l_valid && s_l_ready;
      r_arm = s_r_valid && s_r_ready;
    end
  end

  // Strobe monitor: records data and counts back-to-back strobes.
  initial begin
    logic prev_l = 1'b0;
    logic prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid_l) begin
        lq.push_back(o_data_l);
        if (prev_l) b2b_l++;
      end
      if (o_valid_r) begin
        rq.push_back(o_data_r);
        if (prev_r) b2b_r++;
      end
      prev_l = o_valid_l;
      prev_r = o_valid_r;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_lq(input int n);
    for (int k = 0; k < 600 && lq.size() < n; k++) step(1);
    chk("wait_lq_size", lq.size(), n);
  endtask

  task automatic wait_rq(input int n);
    for (int k = 0; k < 600 && rq.size() < n; k++) step(1);
    chk("wait_rq_size", rq.size(), n);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 600 && o_busy; k++) step(1);
    chk("wait_idle", o_busy, 0);
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_valid_l", o_valid_l, 0);
    chk("rst_valid_r", o_valid_r, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_row", o_row_idx, 0);
    chk("rst_fdone", o_frame_done, 0);
    rst = 1'b0;
    step(3);
    chk("idle_busy", o_busy, 0);
    chk("idle_ready_l", s_l_ready, 0);
    chk("idle_no_strobe", lq.size(), 0);

    // Row A: both sources always valid, enable dropped right after start
    l_gate = 1'b1;
    r_gate = 1'b1;
    i_enable = 1'b1;
    step(1);
    chk("a_ready_l0", s_l_ready, 1);
    chk("a_ready_r0", s_r_ready, 1);
    chk("a_busy", o_busy, 1);
    chk("a_valid_l0", o_valid_l, 0);
    i_enable = 1'b0;
    step(1);
    chk("a_strobe1_l", o_valid_l, 1);
    chk("a_data1_l", o_data_l, 1);
    chk("a_strobe1_r", o_valid_r, 1);
    chk("a_ready_l1", s_l_ready, 0);
    step(1);
    chk("a_gap_valid_l", o_valid_l, 0);
    chk("a_hold_data_l", o_data_l, 1);
    chk("a_ready_l2", s_l_ready, 1);
    step(13);
    chk("a_strobe8_l", o_valid_l, 1);
    chk("a_data8_l", o_data_l, 8);
    chk("a_data8_r", o_data_r, 8);
    step(1);
    chk("a_overflow_ready_l", s_l_ready, 0);
    chk("a_overflow_ready_r", s_r_ready, 0);
    chk("a_post_busy", o_busy, 1);
    step(4);
    chk("a_gap_end_busy", o_busy, 1);
    chk("a_gap_end_row", o_row_idx, 0);
    step(1);
    chk("a_done_busy", o_busy, 0);
    chk("a_done_row", o_row_idx, 1);
    chk("a_count_l", lq.size(), 8);
    chk("a_count_r", rq.size(), 8);

    // Row B: left source stalls randomly; last row of the frame
    l_stall = 1'b1;
    i_enable = 1'b1;
    step(1);
    i_enable = 1'b0;
    wait_idle();
    chk("b_fdone_pulse", o_frame_done, 1);
    chk("b_row_wrap", o_row_idx, 0);
    chk("b_count_l", lq.size(), 16);
    chk("b_count_r", rq.size(), 16);
    step(1);
    chk("b_fdone_clear", o_frame_done, 0);
    l_stall = 1'b0;

    // Row C: right source 10 cycles late, enable held into row D
    r_gate = 1'b0;
    i_enable = 1'b1;
    step(10);
    r_gate = 1'b1;
    wait_rq(20);
    chk("c_left_finished", lq.size(), 24);
    chk("c_left_ready_off", s_l_ready, 0);
    chk("c_busy_waiting", o_busy, 1);
    wait_rq(24);
    chk("c_row_at_last", o_row_idx, 0);
    step(5);
    chk("c_row_in_gap", o_row_idx, 0);
    chk("c_busy_in_gap", o_busy, 1);
    step(1);
    chk("c_row_next", o_row_idx, 1);
    chk("c_busy_cont", o_busy, 1);
    i_enable = 1'b0;

    // Row D: asynchronous reset mid-row during a strobe
    wait_lq(27);
    chk("d_strobe_live", o_valid_l, 1);
    chk("d_count_r", rq.size(), 27);
    rst = 1'b1;
    #1;
    chk("d_rst_valid_l", o_valid_l, 0);
    chk("d_rst_data_l", o_data_l, 0);
    chk("d_rst_valid_r", o_valid_r, 0);
    chk("d_rst_data_r", o_data_r, 0);
    chk("d_rst_busy", o_busy, 0);
    chk("d_rst_row", o_row_idx, 0);
    chk("d_rst_ready_l", s_l_ready, 0);
    step(1);
    rst = 1'b0;
    step(5);
    chk("d_idle_no_strobe", lq.size(), 27);
    chk("d_idle_busy", o_busy, 0);
    chk("d_idle_ready_r", s_r_ready, 0);

    // Row E: fresh row after reset, source pointer continues
    i_enable = 1'b1;
    step(1);
    i_enable = 1'b0;
    wait_idle();
    chk("e_row", o_row_idx, 1);
    chk("e_fdone", o_frame_done, 0);
    chk("e_count_l", lq.size(), 35);
    chk("e_count_r", rq.size(), 35);

    // Whole-run data order and strobe spacing
    for (int i = 0; i < lq.size(); i++) chk("order_l", lq[i], i + 1);
    for (int i = 0; i < rq.size(); i++) chk("order_r", rq[i], i + 1);
    chk("b2b_l", b2b_l, 0);
    chk("b2b_r", b2b_r, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
